counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one 4-bit loadable counter.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port req, input, N_REQ bits, a level request per requester.
REQ-005 The block SHALL have port req_len, input, 4*N_REQ bits, with requester i's interval length on bits [4i+3:4i] (range 0..15).
REQ-006 The block SHALL have port grant, output, N_REQ bits, a one-hot one-cycle pulse marking acceptance of a request.
REQ-007 The block SHALL have port done, output, N_REQ bits, a one-hot one-cycle pulse marking interval completion for the owner.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-009 The block SHALL have port owner, output, 2 bits, giving the index of the current or last granted requester.

Function
REQ-010 The FSM SHALL have states IDLE, LOAD, COUNT and DONE, held in a registered state variable.
REQ-011 In IDLE with any req bit set, the FSM SHALL pick the winner round-robin, starting the search at rr_ptr and ascending modulo N_REQ.
REQ-012 In the same IDLE cycle it SHALL pulse grant[winner], latch owner and req_len of the winner, and go to LOAD.
REQ-013 In IDLE with req all zero, the FSM SHALL stay in IDLE with grant and done zero.
REQ-014 req and req_len SHALL be sampled only in IDLE; changes after grant SHALL have no effect on the running interval.
REQ-015 In LOAD, the FSM SHALL drive the counter load=1 with loadVal = 4'd15 - len (4-bit unsigned, no overflow for 0..15), then go to COUNT.
REQ-016 In COUNT, the counter SHALL increment by one per cycle; when its value equals 4'hF the FSM SHALL go to DONE.
REQ-017 In DONE, the FSM SHALL pulse done[owner] for exactly one cycle, set rr_ptr = (owner+1) mod N_REQ, and return to IDLE.
REQ-018 Latency: for grant in cycle T, done SHALL pulse in cycle T+3+len; len=0 therefore completes at T+3.
REQ-019 A requester still asserting req after its done SHALL compete normally, with no back-to-back grant in the DONE cycle; the earliest regrant is the cycle after DONE.
REQ-020 The counter SHALL never wrap 15->0 while in COUNT; wrap is reachable only outside COUNT and is ignored there.
REQ-021 busy SHALL be 1 in LOAD, COUNT and DONE, and 0 in IDLE.

Reset
REQ-022 When rst=1 at a clock edge, the next state SHALL be IDLE, with rr_ptr=0, owner=0, latched len=0, grant=0, done=0, busy=0 and counter value 0.
REQ-023 Reset asserted mid-operation (LOAD, COUNT or DONE) SHALL abort the interval with no done pulse; rst SHALL take priority over all other inputs.

Structure
REQ-024 The state encoding, the 4-bit counter width and the terminal value 4'hF SHALL live in a shared package, counter_sched_pkg.
REQ-025 The counter SHALL be one instantiated sub-module, tick_cnt4: 4-bit, synchronous active-high reset, load taking priority over increment, wrapping 15->0.

Verification
REQ-026 Bench: req=0001, len0=5 -> grant=0001 at T, busy T+1..T+8, done=0001 at T+8, owner=0.
REQ-027 Bench: req=0010, len1=0 -> grant[1] at T, done[1] at T+3; len1=15 -> done[1] at T+18.
REQ-028 Bench: from reset, req=1111 held with all len=1 -> grants in order 0,1,2,3 then 0, each done at grant+4.
REQ-029 Bench: after owner 2 completes, req=1001 -> grant[3] before grant[0].
REQ-030 Bench: rst pulsed in COUNT with len=10 -> cycle after: busy=0, owner=0, no done; next req=0100 -> grant[2] from rr_ptr=0 search.
REQ-031 Bench: req_len changed during COUNT -> done timing unchanged from latched len.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg -- shared definitions for the counter scheduler.
//   CNT_W     : width of the shared interval counter
//   CNT_TERM  : terminal count that ends an interval
//   ST_*      : FSM state encoding
//   load_val  : counter preload so that the terminal count is reached after 'len' increments
package counter_sched_pkg;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_TERM = 4'hF;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // 0..15 maps onto 15..0, so the subtraction never underflows.
   function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] len);
      return CNT_TERM - len;
   endfunction

endpackage

// File: rtl/counter_sched_cnt.sv
// tick_cnt4 -- 4-bit loadable up-counter.
//   clk_i      : clock (posedge)
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (wins over inc_i)
//   inc_i      : increment by one, wrapping 15 -> 0
//   load_val_i : preload value
//   cnt_o      : current count
module tick_cnt4
   import counter_sched_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)       cnt_q <= '0;
      else if (load_i) cnt_q <= load_val_i;
      else if (inc_i)  cnt_q <= cnt_q + 1'b1;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/counter_sched.sv
// counter_sched -- round-robin scheduler sharing one 4-bit interval counter
// among N_REQ requesters (N_REQ <= 4, owner is 2 bits wide).
//   clk     : clock (posedge)
//   rst     : synchronous active-high reset, aborts any running interval
//   req     : level request per requester, sampled only in IDLE
//   req_len : interval length per requester, 4 bits each, lane i at [4i+3:4i]
//   grant   : one-hot pulse in the IDLE cycle a request is accepted
//   done    : one-hot pulse in the DONE cycle for the owner
//   busy    : high outside IDLE
//   owner   : index of the current / last granted requester
module counter_sched
   import counter_sched_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [CNT_W*N_REQ-1:0] req_len,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [1:0]             owner
);

   logic [1:0]       state_q, state_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [1:0]       owner_q, owner_d;
   logic [CNT_W-1:0] len_q, len_d;

   logic             cnt_load, cnt_inc;
   logic [CNT_W-1:0] cnt;

   logic             found;
   logic [1:0]       win;
   int               idx;

   tick_cnt4 u_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (cnt_load),
      .inc_i      (cnt_inc),
      .load_val_i (load_val(len_q)),
      .cnt_o      (cnt)
   );

   // Round-robin search: first set req bit at or after rr_ptr, modulo N_REQ.
   always_comb begin
      found = 1'b0;
      win   = rr_ptr_q;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = 2'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      len_d    = len_q;
      grant    = '0;
      done     = '0;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant[win] = 1'b1;
               owner_d    = win;
               len_d      = req_len[CNT_W*int'(win) +: CNT_W];
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_load = 1'b1;
            state_d  = ST_COUNT;
         end
         ST_COUNT: begin
            // Hold at the terminal value rather than increment, so the
            // counter never wraps while an interval is running.
            if (cnt == CNT_TERM) state_d = ST_DONE;
            else                 cnt_inc = 1'b1;
         end
         default: begin // ST_DONE
            done[owner_q] = 1'b1;
            rr_ptr_d      = 2'((int'(owner_q) + 1) % N_REQ);
            state_d       = ST_IDLE;
         end
      endcase
      // Reset overrides everything, including the combinational pulses.
      if (rst) begin
         grant = '0;
         done  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         len_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         len_q    <= len_d;
      end
   end

   assign busy  = (state_q != ST_IDLE);
   assign owner = owner_q;

endmodule

// File: tb/tb_counter_sched.sv
module tb_counter_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] req_len = '0;
   logic [3:0]  grant, done;
   logic        busy;
   logic [1:0]  owner;

   typedef struct {
      logic [3:0] g;
      logic [3:0] d;
      int         cyc;
   } ev_t;

   typedef struct {
      logic [3:0]  r;
      logic [15:0] lens;
      int          win;
   } vec_t;

   ev_t  sb[$];
   ev_t  me;
   vec_t vt[7];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   counter_sched #(.N_REQ(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .req_len (req_len),
      .grant   (grant),
      .done    (done),
      .busy    (busy),
      .owner   (owner)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic ev_t mk(input logic [3:0] g, input logic [3:0] d, input int c);
      ev_t e;
      e.g = g;
      e.d = d;
      e.cyc = c;
      return e;
   endfunction

   // Scoreboard check: every grant/done pulse must match the oldest expected event.
   always @(negedge clk) begin
      #2;
      if (grant != 0 || done != 0) begin
         if (sb.size() == 0) chk("unexpected pulse", int'({grant, done}), 0);
         else begin
            me = sb.pop_front();
            chk("grant", int'(grant), int'(me.g));
            chk("done", int'(done), int'(me.d));
            chk("event cycle", cyc, me.cyc);
         end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
         me = sb.pop_front();
         chk("missed event cycle", -1, me.cyc);
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) return;
      end
      chk("idle timeout", 1, 0);
   endtask

   // One isolated request: grant now, done at +3+len, busy through done.
   task automatic run_one(input logic [3:0] r, input logic [15:0] lens, input int win, input bit chg);
      int len, c;
      wait_idle();
      len = int'(lens[win*4 +: 4]);
      req = r;
      req_len = lens;
      c = cyc;
      sb.push_back(mk(4'(1 << win), 4'd0, c));
      sb.push_back(mk(4'd0, 4'(1 << win), c + 3 + len));
      for (int k = 1; k <= len + 4; k++) begin
         @(negedge clk);
         if (k == 1) req = '0;
         if (chg && k == 3) req_len = ~lens;
         #2;
         chk("busy", int'(busy), (k <= len + 3) ? 1 : 0);
         if (k == 1) chk("owner", int'(owner), win);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      vt[0] = '{4'b0001, 16'h0005, 0};
      vt[1] = '{4'b0010, 16'h0000, 1};
      vt[2] = '{4'b0010, 16'h00F0, 1};
      vt[3] = '{4'b1000, 16'h7000, 3};
      vt[4] = '{4'b0011, 16'h0093, 0};  // rr=0 after owner 3
      vt[5] = '{4'b0110, 16'h0420, 1};  // rr=1
      vt[6] = '{4'b1100, 16'h8100, 2};  // rr=2

      // Reset: requests ignored while rst is high.
      repeat (3) @(negedge clk);
      req = 4'hF;
      req_len = 16'h1111;
      #2;
      chk("grant in reset", int'(grant), 0);
      chk("busy in reset", int'(busy), 0);
      chk("done in reset", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      #2;
      chk("busy after reset", int'(busy), 0);
      chk("owner after reset", int'(owner), 0);
      chk("grant idle no req", int'(grant), 0);

      // All four requesting, len=1: rotation 0,1,2,3,0, period 5.
      @(negedge clk);
      req = 4'hF;
      req_len = 16'h1111;
      c = cyc;
      for (int k = 0; k < 5; k++) begin
         sb.push_back(mk(4'(1 << (k % 4)), 4'd0, c + 5*k));
         sb.push_back(mk(4'd0, 4'(1 << (k % 4)), c + 5*k + 4));
      end
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (k == 21) req = '0;
      end

      foreach (vt[i]) run_one(vt[i].r, vt[i].lens, vt[i].win, 1'b0);

      // Owner 2 just finished, rr=3: 3 must be served before 0.
      wait_idle();
      req = 4'b1001;
      req_len = 16'h1001;
      c = cyc;
      sb.push_back(mk(4'b1000, 4'd0, c));
      sb.push_back(mk(4'd0, 4'b1000, c + 4));
      sb.push_back(mk(4'b0001, 4'd0, c + 5));
      sb.push_back(mk(4'd0, 4'b0001, c + 9));
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 6) req = '0;
      end

      // Held single request, len=0: regrant only the cycle after DONE.
      wait_idle();
      req = 4'b0001;
      req_len = 16'h0000;
      c = cyc;
      sb.push_back(mk(4'b0001, 4'd0, c));
      sb.push_back(mk(4'd0, 4'b0001, c + 3));
      sb.push_back(mk(4'b0001, 4'd0, c + 4));
      sb.push_back(mk(4'd0, 4'b0001, c + 7));
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 5) req = '0;
      end

      // Reset mid-COUNT: interval aborted, no done, rr pointer back to 0.
      wait_idle();
      req = 4'b0010;
      req_len = 16'h00A0;
      c = cyc;
      sb.push_back(mk(4'b0010, 4'd0, c));
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1) req = '0;
         if (k == 2) begin
            #2;
            chk("owner before abort", int'(owner), 1);
         end
         if (k == 3) rst = 1'b1;
         if (k == 4) begin
            rst = 1'b0;
            #2;
            chk("busy after abort", int'(busy), 0);
            chk("owner after abort", int'(owner), 0);
            chk("done after abort", int'(done), 0);
         end
      end
      run_one(4'b0101, 16'h0202, 0, 1'b0);  // rr=0 picks 0 (stale rr=1 would pick 2)
      run_one(4'b0100, 16'h0300, 2, 1'b0);

      // req_len changes mid-interval must not move done.
      run_one(4'b0001, 16'h0006, 0, 1'b1);

      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
